cond_exec_em: RTL
=================

Name: cond_exec_em

Overview:
- Execute-stage consumer of the decode/execute control register.
- Owns the architectural NZCV flags register.
- Evaluates each instruction's condition field against the flags and gates its side-effect controls (register write, memory write, PC write, branch, flag write).
- Registers the gated controls into the memory stage, with stall/flush support from the hazard unit.
- Current flags are fed back to decode as the Flags input of the decode/execute register.

Parameters:
- FLAGS_INIT, 4'b0000, reset value of the NZCV register ([3]=N, [2]=Z, [1]=C, [0]=V).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- PCSrcE  input  1  PC write request from execute stage
- RegWriteE  input  1  register write request
- MemtoRegE  input  1  writeback source select
- MemWriteE  input  1  memory write request
- BranchE  input  1  instruction is a branch
- FlagWriteE  input  2  [1]: update N,Z; [0]: update C,V
- CondE  input  4  ARM condition field
- ALUFlags  input  4  NZCV produced by the ALU this cycle
- StallM  input  1  hold execute/memory boundary
- FlushM  input  1  kill the instruction in execute
- CondExE  output  1  condition passed (combinational)
- BranchTakenE  output  1  BranchE & CondExE (combinational)
- Flags  output  4  current NZCV register value (to decode stage)
- PCSrcM  output  1  registered gated PC write
- RegWriteM  output  1  registered gated register write
- MemtoRegM  output  1  registered MemtoRegE, not gated
- MemWriteM  output  1  registered gated memory write

Behaviour:
- Reset: asynchronous, active-high, highest priority.
  - Flags = FLAGS_INIT.
  - PCSrcM, RegWriteM, MemtoRegM, MemWriteM = 0.
- Condition decode is combinational on CondE and the Flags register (not on any pipelined flag copy):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (never executes)
- CondExE and BranchTakenE have zero latency and are valid in the same cycle as the inputs.
- Flag register update, on posedge clk when not in reset:
  - Write occurs only when CondExE & ~StallM & ~FlushM.
  - FlagWriteE[1] loads N,Z from ALUFlags[3:2].
  - FlagWriteE[0] loads C,V from ALUFlags[1:0].
  - Bits not enabled hold their value. FlagWriteE=00 leaves the register unchanged.
  - The new flags are visible on Flags and to the condition logic from the following cycle.
  - The instruction that writes the flags is evaluated against the old flags.
- E/M register, on posedge clk, priority reset > FlushM > StallM > load:
  - FlushM=1: all M outputs = 0 (bubble), even if StallM=1.
  - StallM=1 (FlushM=0): all M outputs hold their value.
  - Otherwise:
    - PCSrcM <= PCSrcE & CondExE
    - RegWriteM <= RegWriteE & CondExE
    - MemWriteM <= MemWriteE & CondExE
    - MemtoRegM <= MemtoRegE
- Latency: exactly 1 cycle from E inputs to M outputs.
- Back-to-back flag setters: the second instruction evaluates against flags written by the first (register is updated at the edge between them).
- Reset asserted mid-stream: M outputs and flags clear immediately without waiting for a clock edge. The first post-reset instruction evaluates against FLAGS_INIT.
- CondExE=0: the instruction is fully suppressed (no register/memory/PC write, no flag write). BranchTakenE=0.
- X on CondE while all request inputs are 0 must not corrupt Flags (write gated by FlagWriteE).

Test Plan:
- Reset, then CondE=1110, RegWriteE=1, MemWriteE=1 -> next cycle RegWriteM=1, MemWriteM=1; Flags=0000.
- CondE=1110, FlagWriteE=11, ALUFlags=0100 -> Flags=0100 next cycle. Following instruction CondE=0000 (EQ), BranchE=1, PCSrcE=1 -> BranchTakenE=1 same cycle, PCSrcM=1 next cycle. With CondE=0001 (NE) instead -> BranchTakenE=0, PCSrcM=0.
- Flags=1111, FlagWriteE=01, ALUFlags=0000 -> Flags=1100. FlagWriteE=10 with ALUFlags=0000 -> Flags=0000.
- GE/LT/GT/LE sweep over all 16 flag values; CondE=1111 with RegWriteE=1, FlagWriteE=11 -> CondExE=0, RegWriteM=0, Flags unchanged.
- StallM=1 for 2 cycles with changing inputs -> M outputs and Flags hold. FlushM=1 together with StallM=1 and a passing flag-setting instruction -> M outputs 0, Flags unchanged.
- Assert reset asynchronously between edges while RegWriteM=1 and Flags=1010 -> both clear before the next edge. After release, CondE=0010 (CS) -> CondExE=0.

Source files
------------

// File: rtl/cond_exec_em.sv
// Execute-stage condition evaluation, NZCV flag register and execute/memory control register.
// Side-effect controls are gated by the condition result before entering the memory stage.
module cond_exec_em #(
   parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       PCSrcE,
   input  logic       RegWriteE,
   input  logic       MemtoRegE,
   input  logic       MemWriteE,
   input  logic       BranchE,
   input  logic [1:0] FlagWriteE,
   input  logic [3:0] CondE,
   input  logic [3:0] ALUFlags,
   input  logic       StallM,
   input  logic       FlushM,
   output logic       CondExE,
   output logic       BranchTakenE,
   output logic [3:0] Flags,
   output logic       PCSrcM,
   output logic       RegWriteM,
   output logic       MemtoRegM,
   output logic       MemWriteM
);

   function automatic logic condPass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         4'b0000: condPass = z;
         4'b0001: condPass = ~z;
         4'b0010: condPass = c;
         4'b0011: condPass = ~c;
         4'b0100: condPass = n;
         4'b0101: condPass = ~n;
         4'b0110: condPass = v;
         4'b0111: condPass = ~v;
         4'b1000: condPass = c & ~z;
         4'b1001: condPass = ~c | z;
         4'b1010: condPass = (n == v);
         4'b1011: condPass = (n != v);
         4'b1100: condPass = ~z & (n == v);
         4'b1101: condPass = z | (n != v);
         4'b1110: condPass = 1'b1;
         default: condPass = 1'b0;
      endcase
   endfunction

   logic flagWrEn;
   logic nzWrEn;
   logic cvWrEn;

   // Execute stage: condition decode against the architectural flags
   assign CondExE      = condPass(CondE, Flags);
   assign BranchTakenE = BranchE & CondExE;

   // Per-field enables keep an unknown condition from disturbing flags when no write is requested
   assign flagWrEn = CondExE & ~StallM & ~FlushM;
   assign nzWrEn   = flagWrEn & FlagWriteE[1];
   assign cvWrEn   = flagWrEn & FlagWriteE[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Flags <= FLAGS_INIT;
      end else begin
         if (nzWrEn) Flags[3:2] <= ALUFlags[3:2];
         if (cvWrEn) Flags[1:0] <= ALUFlags[1:0];
      end
   end

   // Execute/memory boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PCSrcM    <= 1'b0;
         RegWriteM <= 1'b0;
         MemtoRegM <= 1'b0;
         MemWriteM <= 1'b0;
      end else if (FlushM) begin
         PCSrcM    <= 1'b0;
         RegWriteM <= 1'b0;
         MemtoRegM <= 1'b0;
         MemWriteM <= 1'b0;
      end else if (!StallM) begin
         PCSrcM    <= PCSrcE & CondExE;
         RegWriteM <= RegWriteE & CondExE;
         MemtoRegM <= MemtoRegE;
         MemWriteM <= MemWriteE & CondExE;
      end
   end

endmodule
